// File: rtl/ahbl_master_port_pkg.sv
// Shared AHB-Lite encodings and data-lane helpers for the ahbl_master_port slice.
// Used by ahbl_master_port; the optional request checking is AHBL_MST_ALIGN_CHECK_EN.
package ahbl_master_port_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_NONSEQ = 2'b10
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_B = 3'd0,
        HSIZE_H = 3'd1,
        HSIZE_W = 3'd2
    } hsize_e;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // Sub-word stores drive every byte lane so the slave can pick any lane.
    function automatic logic [DATA_WIDTH-1:0] replicate_wdata(
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [2:0]            size
    );
        case (size)
            HSIZE_B: replicate_wdata = {4{wdata[7:0]}};
            HSIZE_H: replicate_wdata = {2{wdata[15:0]}};
            default: replicate_wdata = wdata;
        endcase
    endfunction

    function automatic logic is_misaligned(
        input logic [1:0] addr_lo,
        input logic [2:0] size
    );
        is_misaligned = (size > HSIZE_W) ||
                        ((size == HSIZE_H) && addr_lo[0]) ||
                        ((size == HSIZE_W) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/ahbl_master_port_if.sv
// AHB-Lite bus bundle between the master port and the interconnect.
interface ahbl_master_port_if;

    logic [31:0] haddr;
    logic [2:0]  hburst;
    logic        hmastlock;
    logic [3:0]  hprot;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic        hwrite;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    modport master (
        output haddr, hburst, hmastlock, hprot, hsize, htrans, hwdata, hwrite,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  haddr, hburst, hmastlock, hprot, hsize, htrans, hwdata, hwrite,
        output hrdata, hready, hresp
    );

endinterface

// File: rtl/ahbl_mst_rdata_align.sv
// Read-data lane extraction: shifts the addressed lane down and zero/sign-extends it.
module ahbl_mst_rdata_align
    import ahbl_master_port_pkg::*;
(
    input  logic [31:0] hrdata,
    input  logic [1:0]  lo,
    input  logic [2:0]  size,
    input  logic        sign,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = hrdata >> {lo, 3'b000};
        case (size)
            HSIZE_B: data = {{24{sign & shifted[7]}}, shifted[7:0]};
            HSIZE_H: data = {{16{sign & shifted[15]}}, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/ahbl_master_port.sv
// AHB-Lite single-transfer initiator: core request/response port onto the bus, pipelined address/data.
// Define AHBL_MST_ALIGN_CHECK_EN to answer misaligned or oversized requests locally with an error.
module ahbl_master_port
    import ahbl_master_port_pkg::*;
#(
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    input  logic                  req_we,
    input  logic [2:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [31:0]           rsp_rdata,
    ahbl_master_port_if.master    ahbl
);

    logic        run_q;
    logic        dp_valid_q,  dp_valid_d;
    logic        dp_we_q,     dp_we_d;
    logic [2:0]  dp_size_q,   dp_size_d;
    logic [1:0]  dp_lo_q,     dp_lo_d;
    logic        dp_signed_q, dp_signed_d;
    logic [31:0] dp_wdata_q,  dp_wdata_d;
    logic        local_err_q, local_err_d;
    logic        bad_req;
    logic        accept;
    logic        issue;
    logic [31:0] aligned_rdata;

`ifdef AHBL_MST_ALIGN_CHECK_EN
    assign bad_req = is_misaligned(req_addr[1:0], req_size);
`else
    assign bad_req = 1'b0;
`endif

    // An ERROR response (either cycle) cancels whatever the core is presenting.
    assign accept = run_q & req_valid & ahbl.hready & ~ahbl.hresp;
    assign issue  = run_q & req_valid & ~ahbl.hresp & ~bad_req;

    assign req_ready      = accept;
    assign ahbl.htrans    = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign ahbl.haddr     = req_addr;
    assign ahbl.hwrite    = req_we;
    assign ahbl.hsize     = req_size;
    assign ahbl.hburst    = HBURST_SINGLE;
    assign ahbl.hmastlock = 1'b0;
    assign ahbl.hprot     = HPROT_VAL;
    assign ahbl.hwdata    = dp_wdata_q;

    always_comb begin
        dp_valid_d  = dp_valid_q;
        dp_we_d     = dp_we_q;
        dp_size_d   = dp_size_q;
        dp_lo_d     = dp_lo_q;
        dp_signed_d = dp_signed_q;
        dp_wdata_d  = dp_wdata_q;
        local_err_d = local_err_q;
        if (ahbl.hready) begin
            dp_valid_d = accept;
            if (accept) begin
                dp_we_d     = req_we;
                dp_size_d   = req_size;
                dp_lo_d     = req_addr[1:0];
                dp_signed_d = req_signed;
                dp_wdata_d  = replicate_wdata(req_wdata, req_size);
                local_err_d = bad_req;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_q       <= 1'b0;
            dp_valid_q  <= 1'b0;
            dp_we_q     <= 1'b0;
            dp_size_q   <= 3'd0;
            dp_lo_q     <= 2'd0;
            dp_signed_q <= 1'b0;
            dp_wdata_q  <= 32'd0;
        end else begin
            run_q       <= 1'b1;
            dp_valid_q  <= dp_valid_d;
            dp_we_q     <= dp_we_d;
            dp_size_q   <= dp_size_d;
            dp_lo_q     <= dp_lo_d;
            dp_signed_q <= dp_signed_d;
            dp_wdata_q  <= dp_wdata_d;
        end
    end

`ifdef AHBL_MST_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            local_err_q <= 1'b0;
        end else begin
            local_err_q <= local_err_d;
        end
    end
`else
    assign local_err_q = 1'b0;
`endif

    ahbl_mst_rdata_align u_rdata_align (
        .hrdata (ahbl.hrdata),
        .lo     (dp_lo_q),
        .size   (dp_size_q),
        .sign   (dp_signed_q),
        .data   (aligned_rdata)
    );

    assign rsp_valid = dp_valid_q & ahbl.hready;
    assign rsp_err   = rsp_valid & (ahbl.hresp | local_err_q);
    assign rsp_rdata = (rsp_valid & ~rsp_err & ~dp_we_q) ? aligned_rdata : 32'd0;

endmodule
